// File: rtl/mem_eeprom_bram_pkg.sv
// Shared definitions for the GBA cartridge EEPROM backing store.
//   EEPROM_BITS / EEPROM_BYTES : array geometry (64 Kbit = 8 KB)
//   A_AW / B_AW                : bit-port and byte-port address widths
//   addr_a_t / addr_b_t        : bit and byte address types
//   INIT_BYTE                  : power-up fill value of the array
// Build option MEM_EEPROM_ERASED_INIT_EN: when defined the array powers up
// erased (all ones); otherwise it powers up all zeros.
package mem_eeprom_bram_pkg;

  localparam int unsigned EEPROM_BITS  = 65536;
  localparam int unsigned EEPROM_BYTES = 8192;
  localparam int unsigned A_AW         = 16;
  localparam int unsigned B_AW         = 13;

  typedef logic [A_AW-1:0] addr_a_t;
  typedef logic [B_AW-1:0] addr_b_t;

`ifdef MEM_EEPROM_ERASED_INIT_EN
  localparam logic [7:0] INIT_BYTE = 8'hFF;
`else
  localparam logic [7:0] INIT_BYTE = 8'h00;
`endif

  // One-hot byte lane mask for a bit position within a byte.
  function automatic logic [7:0] bit_lane_mask(input logic [2:0] sel);
    logic [7:0] m;
    m = 8'h01 << sel;
    return m;
  endfunction

endpackage

// File: rtl/mem_eeprom_bram_if.sv
// Port bundle for the EEPROM backing store.
//   Port A (bit port)  : cea, ada[15:0], wrea, dina, ocea -> douta
//   Port B (byte port) : ceb, adb[12:0], wreb, dinb[7:0], oceb -> doutb
// master: the requester (protocol engine / CPU side); slave: the RAM.
interface mem_eeprom_bram_if;
  import mem_eeprom_bram_pkg::*;

  logic       cea;
  addr_a_t    ada;
  logic       wrea;
  logic       dina;
  logic       ocea;
  logic       douta;

  logic       ceb;
  addr_b_t    adb;
  logic       wreb;
  logic [7:0] dinb;
  logic       oceb;
  logic [7:0] doutb;

  modport master (
    output cea, ada, wrea, dina, ocea,
    output ceb, adb, wreb, dinb, oceb,
    input  douta, doutb
  );

  modport slave (
    input  cea, ada, wrea, dina, ocea,
    input  ceb, adb, wreb, dinb, oceb,
    output douta, doutb
  );

endinterface

// File: rtl/mem_eeprom_bram_bank.sv
// Byte-wide dual-address RAM with a per-bit write mask on each port.
//   clk              : clock
//   we_a/addr_a/...  : write enable, byte address, bit mask, data, read data
//   we_b/addr_b/...  : same for the second port
// Reads are combinational and return the pre-edge contents, so a register
// placed after rdata gives read-first behaviour. The caller must never
// present two enabled writes to the same byte in one cycle.
// Power-up contents follow INIT_BYTE (see MEM_EEPROM_ERASED_INIT_EN).
module mem_eeprom_bram_bank
  import mem_eeprom_bram_pkg::*;
(
  input  logic       clk,
  input  logic       we_a,
  input  addr_b_t    addr_a,
  input  logic [7:0] mask_a,
  input  logic [7:0] din_a,
  output logic [7:0] rdata_a,
  input  logic       we_b,
  input  addr_b_t    addr_b,
  input  logic [7:0] mask_b,
  input  logic [7:0] din_b,
  output logic [7:0] rdata_b
);

  logic [7:0] mem [EEPROM_BYTES] = '{default: INIT_BYTE};

  always_ff @(posedge clk) begin
    if (we_b) mem[addr_b] <= (mem[addr_b] & ~mask_b) | (din_b & mask_b);
    if (we_a) mem[addr_a] <= (mem[addr_a] & ~mask_a) | (din_a & mask_a);
  end

  assign rdata_a = mem[addr_a];
  assign rdata_b = mem[addr_b];

endmodule

// File: rtl/mem_eeprom_bram.sv
// Mixed-width true dual-port RAM holding the 64 Kbit GBA EEPROM image.
//   clk : single clock for both ports
//   rst : synchronous active-high; clears douta/doutb only, never the array
//   bus : slave side of mem_eeprom_bram_if
//         port A = 1-bit port on a 16-bit bit address (protocol engine)
//         port B = 8-bit port on a 13-bit byte address (control CPU)
// Bit address ada maps to byte ada[15:3], bit ada[2:0] (bit 0 = LSB).
// Outputs are registered, read-first, and only update when ce & oce.
// Build option MEM_EEPROM_ERASED_INIT_EN selects an all-ones power-up image.
module mem_eeprom_bram
  import mem_eeprom_bram_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  mem_eeprom_bram_if.slave   bus
);

  addr_b_t    byte_a;
  logic [2:0] bit_sel_a;
  logic       wr_a;
  logic       wr_b;
  logic       collide;
  logic [7:0] mask_a;
  logic [7:0] din_a;
  logic       bank_we_a;
  logic [7:0] bank_din_b;
  logic [7:0] rdata_a;
  logic [7:0] rdata_b;

  logic       douta_d, douta_q;
  logic [7:0] doutb_d, doutb_q;

  assign byte_a    = bus.ada[15:3];
  assign bit_sel_a = bus.ada[2:0];
  assign wr_a      = bus.cea & bus.wrea;
  assign wr_b      = bus.ceb & bus.wreb;
  assign mask_a    = bit_lane_mask(bit_sel_a);
  assign din_a     = {8{bus.dina}};
  assign collide   = wr_a & wr_b & (byte_a == bus.adb);

  // On a same-byte collision the A bit is folded into B's full-byte write
  // (B first, A's bit on top), so the bank never sees two writes to one byte.
  always_comb begin
    bank_we_a  = wr_a & ~collide;
    bank_din_b = bus.dinb;
    if (collide) bank_din_b = (bus.dinb & ~mask_a) | (din_a & mask_a);
  end

  mem_eeprom_bram_bank u_bank (
    .clk     (clk),
    .we_a    (bank_we_a),
    .addr_a  (byte_a),
    .mask_a  (mask_a),
    .din_a   (din_a),
    .rdata_a (rdata_a),
    .we_b    (wr_b),
    .addr_b  (bus.adb),
    .mask_b  (8'hFF),
    .din_b   (bank_din_b),
    .rdata_b (rdata_b)
  );

  always_comb begin
    douta_d = douta_q;
    doutb_d = doutb_q;
    if (rst) begin
      douta_d = 1'b0;
      doutb_d = 8'h00;
    end else begin
      if (bus.cea && bus.ocea) douta_d = rdata_a[bit_sel_a];
      if (bus.ceb && bus.oceb) doutb_d = rdata_b;
    end
  end

  always_ff @(posedge clk) begin
    douta_q <= douta_d;
    doutb_q <= doutb_d;
  end

  assign bus.douta = douta_q;
  assign bus.doutb = doutb_q;

endmodule

// File: tb/tb_mem_eeprom_bram.sv
// Scoreboard bench for mem_eeprom_bram: each driven cycle pushes the expected
// registered outputs (from a byte-array model of the EEPROM image) into a
// queue; a monitor pops one entry per clock and compares it against the DUT.
module tb_mem_eeprom_bram;
  import mem_eeprom_bram_pkg::*;

  typedef struct packed {
    logic        ea;
    logic [7:0]  eb;
    int unsigned idx;
  } exp_t;

  logic clk;
  logic rst;
  mem_eeprom_bram_if bus();

  mem_eeprom_bram dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0]  model [8192];
  logic        exp_a;
  logic [7:0]  exp_b;
  exp_t        sb [$];
  int unsigned step_no;
  int          n_pass;
  int          n_total;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input logic r,
                      input logic ce_a, input logic [15:0] a_a, input logic we_a,
                      input logic d_a, input logic oce_a,
                      input logic ce_b, input logic [12:0] a_b, input logic we_b,
                      input logic [7:0] d_b, input logic oce_b);
    exp_t e;
    @(negedge clk);
    rst      = r;
    bus.cea  = ce_a; bus.ada = a_a; bus.wrea = we_a; bus.dina = d_a; bus.ocea = oce_a;
    bus.ceb  = ce_b; bus.adb = a_b; bus.wreb = we_b; bus.dinb = d_b; bus.oceb = oce_b;
    // Expected capture uses the image as it stands before this edge's writes.
    if (r) begin
      exp_a = 1'b0;
      exp_b = 8'h00;
    end else begin
      if (ce_a && oce_a) exp_a = model[a_a / 8][a_a % 8];
      if (ce_b && oce_b) exp_b = model[a_b];
    end
    e.ea  = exp_a;
    e.eb  = exp_b;
    e.idx = step_no;
    step_no++;
    sb.push_back(e);
    // Writes commit even under reset: byte port first, then the bit port.
    if (ce_b && we_b) model[a_b] = d_b;
    if (ce_a && we_a) model[a_a / 8][a_a % 8] = d_a;
  endtask

  // Monitor: one expected entry per clock edge following a driven cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_total++;
        if (bus.douta === e.ea) n_pass++;
        else $display("FAIL douta step %0d: got %b want %b", e.idx, bus.douta, e.ea);
        n_total++;
        if (bus.doutb === e.eb) n_pass++;
        else $display("FAIL doutb step %0d: got %h want %h", e.idx, bus.doutb, e.eb);
      end
    end
  end

  initial begin
    logic [12:0] rb;
    logic [15:0] ra;
    int          waited;
    n_pass  = 0;
    n_total = 0;
    step_no = 0;
    exp_a   = 1'b0;
    exp_b   = 8'h00;
    for (int i = 0; i < 8192; i++) begin
`ifdef MEM_EEPROM_ERASED_INIT_EN
      model[i] = 8'hFF;
`else
      model[i] = 8'h00;
`endif
    end
    rst = 1'b1;
    bus.cea = 0; bus.ada = '0; bus.wrea = 0; bus.dina = 0; bus.ocea = 0;
    bus.ceb = 0; bus.adb = '0; bus.wreb = 0; bus.dinb = '0; bus.oceb = 0;

    // Reset, then idle, then power-up read of byte 0.
    step(1, 0, 16'h0, 0, 0, 0, 0, 13'h0, 0, 8'h00, 0);
    step(1, 0, 16'h0, 0, 0, 0, 0, 13'h0, 0, 8'h00, 0);
    step(0, 0, 16'h0, 0, 0, 0, 0, 13'h0, 0, 8'h00, 0);
    step(0, 1, 16'h0, 0, 0, 1, 1, 13'h0, 0, 8'h00, 1);

    // B writes 0x5A to byte 0x1234, A reads the eight bits back.
    step(0, 0, 16'h0, 0, 0, 0, 1, 13'h1234, 1, 8'h5A, 1);
    for (int i = 0; i < 8; i++)
      step(0, 1, 16'h91A0 + 16'(i), 0, 0, 1, 0, 13'h0, 0, 8'h00, 0);

    // A sets top and bottom bits of the last byte; neighbour untouched.
    step(0, 1, 16'hFFF8, 1, 1, 0, 0, 13'h0, 0, 8'h00, 0);
    step(0, 1, 16'hFFFF, 1, 1, 0, 0, 13'h0, 0, 8'h00, 0);
    step(0, 0, 16'h0, 0, 0, 0, 1, 13'h1FFF, 0, 8'h00, 1);
    step(0, 0, 16'h0, 0, 0, 0, 1, 13'h1FFE, 0, 8'h00, 1);

    // Read-first on a B write.
    step(0, 0, 16'h0, 0, 0, 0, 1, 13'h7, 1, 8'hA5, 0);
    step(0, 0, 16'h0, 0, 0, 0, 1, 13'h7, 1, 8'h3C, 1);
    step(0, 0, 16'h0, 0, 0, 0, 1, 13'h7, 0, 8'h00, 1);

    // Same-byte collision: A's bit wins over B's byte; A reads old bit.
    step(0, 1, 16'h0013, 1, 1, 1, 1, 13'h2, 1, 8'h00, 1);
    step(0, 1, 16'h0013, 0, 0, 1, 1, 13'h2, 0, 8'h00, 1);

    // Output hold with oceb low, and with ceb low.
    step(0, 0, 16'h0, 0, 0, 0, 1, 13'h1234, 0, 8'h00, 0);
    step(0, 0, 16'h0, 0, 0, 0, 1, 13'h0100, 0, 8'h00, 0);
    step(0, 0, 16'h0, 0, 0, 1, 0, 13'h1FFF, 0, 8'h00, 1);

    // Reset mid-stream with a read and a write pending; contents survive.
    step(1, 1, 16'h91A1, 0, 0, 1, 1, 13'h0555, 1, 8'hC3, 1);
    step(0, 1, 16'h91A1, 0, 0, 1, 1, 13'h1234, 0, 8'h00, 1);
    step(0, 0, 16'h0, 0, 0, 0, 1, 13'h0555, 0, 8'h00, 1);

    // Random traffic, biased onto a few bytes so collisions occur.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        rb = 13'($urandom_range(0, 3));
        ra = {13'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
      end else begin
        rb = 13'($urandom);
        ra = 16'($urandom);
      end
      step(($urandom_range(0, 49) == 0),
           1'($urandom), ra, 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), rb, 1'($urandom), 8'($urandom), 1'($urandom));
    end

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
